// File: rtl/cgra_kernel_scheduler_if.sv
// cgra_kernel_scheduler_if: request, launch, completion and status signals of the kernel scheduler.
interface cgra_kernel_scheduler_if #(
  parameter int N_COLS = 4,
  parameter int KID_W  = 4,
  parameter int QDEPTH = 4
) ();
  logic                        enable_i;
  logic                        req_valid_i;
  logic                        req_ready_o;
  logic [KID_W-1:0]            req_kid_i;
  logic [$clog2(N_COLS):0]     req_ncols_i;
  logic                        launch_valid_o;
  logic                        launch_ready_i;
  logic [KID_W-1:0]            launch_kid_o;
  logic [N_COLS-1:0]           launch_col_mask_o;
  logic                        done_valid_i;
  logic [N_COLS-1:0]           done_col_mask_i;
  logic                        intr_o;
  logic                        intr_clr_i;
  logic [N_COLS-1:0]           busy_o;
  logic [$clog2(QDEPTH):0]     q_count_o;
  logic                        err_o;
  modport master (
    output enable_i, req_valid_i, req_kid_i, req_ncols_i, launch_ready_i,
           done_valid_i, done_col_mask_i, intr_clr_i,
    input  req_ready_o, launch_valid_o, launch_kid_o, launch_col_mask_o,
           intr_o, busy_o, q_count_o, err_o
  );
  modport slave (
    input  enable_i, req_valid_i, req_kid_i, req_ncols_i, launch_ready_i,
           done_valid_i, done_col_mask_i, intr_clr_i,
    output req_ready_o, launch_valid_o, launch_kid_o, launch_col_mask_o,
           intr_o, busy_o, q_count_o, err_o
  );
endinterface

// File: rtl/cgra_kernel_scheduler.sv
// cgra_kernel_scheduler: in-order kernel request FIFO allocating lowest-index free CGRA columns.
module cgra_kernel_scheduler #(
  parameter int N_COLS = 4,
  parameter int KID_W  = 4,
  parameter int QDEPTH = 4
) (
  input logic clk_i,
  input logic rst_i,
  cgra_kernel_scheduler_if.slave s
);
  localparam int CW = $clog2(N_COLS) + 1;
  localparam int QW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic {IDLE, LAUNCH} state_t;
  state_t            r_state;
  logic [KID_W-1:0]  r_kid [QDEPTH];
  logic [CW-1:0]     r_nc [QDEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [QW-1:0]     r_cnt;
  logic [N_COLS-1:0] r_busy, r_mask;
  logic [KID_W-1:0]  r_lkid;
  logic              r_intr, r_err;
  logic              w_acc, w_bad, w_push, w_pop;
  logic [CW-1:0]     w_nfree;
  logic [N_COLS-1:0] w_alloc, w_rel;
  // Free columns come from registered busy only; the head request takes the lowest ones.
  always_comb begin
    w_nfree = '0;
    w_alloc = '0;
    for (int i = 0; i < N_COLS; i++)
      if (!r_busy[i]) begin
        w_alloc[i] = w_nfree < r_nc[r_rp];
        w_nfree = w_nfree + CW'(1);
      end
  end
  assign s.req_ready_o = (r_cnt != QW'(QDEPTH)) & ~rst_i;
  assign w_acc  = s.req_valid_i & s.req_ready_o;
  assign w_bad  = (s.req_ncols_i == '0) || (s.req_ncols_i > CW'(N_COLS));
  assign w_push = w_acc & ~w_bad;
  assign w_pop  = (r_state == IDLE) && (r_cnt != '0) && s.enable_i && (w_nfree >= r_nc[r_rp]);
  assign w_rel  = s.done_valid_i ? s.done_col_mask_i : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_busy  <= '0;
      r_mask  <= '0;
      r_lkid  <= '0;
      r_intr  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_kid[r_wp] <= s.req_kid_i;
        r_nc[r_wp]  <= s.req_ncols_i;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt  <= r_cnt + QW'(w_push) - QW'(w_pop);
      r_busy <= (r_busy & ~w_rel) | (w_pop ? w_alloc : '0);
      r_err  <= (w_acc & w_bad) | (|(w_rel & ~r_busy));
      r_intr <= s.done_valid_i | (r_intr & ~s.intr_clr_i);
      if (r_state == IDLE && w_pop) begin
        r_state <= LAUNCH;
        r_lkid  <= r_kid[r_rp];
        r_mask  <= w_alloc;
      end else if (r_state == LAUNCH && s.launch_ready_i) r_state <= IDLE;
    end
  end
  assign s.launch_valid_o    = r_state == LAUNCH;
  assign s.launch_kid_o      = r_lkid;
  assign s.launch_col_mask_o = r_mask;
  assign s.intr_o            = r_intr;
  assign s.busy_o            = r_busy;
  assign s.q_count_o         = r_cnt;
  assign s.err_o             = r_err;
endmodule

// File: tb/tb_cgra_kernel_scheduler.sv
// tb_cgra_kernel_scheduler: directed stimulus with a launch scoreboard checked by an independent monitor.
module tb_cgra_kernel_scheduler;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  always #5 clk = ~clk;
  cgra_kernel_scheduler_if #(.N_COLS(4), .KID_W(4), .QDEPTH(4)) b ();
  cgra_kernel_scheduler #(.N_COLS(4), .KID_W(4), .QDEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .s(b));
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: every completed launch handshake is matched against the next expected {kid,mask}.
  always @(negedge clk) begin
    if (!rst && b.launch_valid_o && b.launch_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_launch", {b.launch_kid_o, b.launch_col_mask_o}, 0);
      else chk("launch_kid_mask", {b.launch_kid_o, b.launch_col_mask_o}, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] kid, input logic [2:0] nc);
    int n = 0;
    b.req_valid_i = 1;
    b.req_kid_i = kid;
    b.req_ncols_i = nc;
    while (!b.req_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("req_ready_timeout", 0, 1);
    tick();
    b.req_valid_i = 0;
  endtask
  task automatic done(input logic [3:0] m, input logic clr);
    b.done_valid_i = 1;
    b.done_col_mask_i = m;
    b.intr_clr_i = clr;
    tick();
    b.done_valid_i = 0;
    b.done_col_mask_i = 0;
    b.intr_clr_i = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || b.launch_valid_o) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
  endtask
  initial begin
    b.enable_i = 1;
    b.req_valid_i = 0;
    b.req_kid_i = 0;
    b.req_ncols_i = 0;
    b.launch_ready_i = 1;
    b.done_valid_i = 0;
    b.done_col_mask_i = 0;
    b.intr_clr_i = 0;
    tick();
    chk("ready_in_reset", b.req_ready_o, 0);
    tick();
    rst = 0;
    #1;
    chk("rst_ready", b.req_ready_o, 1);
    chk("rst_lvalid", b.launch_valid_o, 0);
    chk("rst_busy", b.busy_o, 0);
    chk("rst_qcount", b.q_count_o, 0);
    chk("rst_intr", b.intr_o, 0);
    chk("rst_err", b.err_o, 0);
    // Latency and allocation of a single 2-column kernel
    exp_q.push_back({4'd3, 4'b0011});
    send(3, 2);
    chk("lat_t1_lvalid", b.launch_valid_o, 0);
    tick();
    chk("lat_t2_lvalid", b.launch_valid_o, 1);
    tick();
    chk("busy_0011", b.busy_o, 4'b0011);
    done(4'b0011, 0);
    chk("busy_freed", b.busy_o, 0);
    // Build busy=0101 then allocate around it
    exp_q.push_back({4'd1, 4'b0001});
    exp_q.push_back({4'd2, 4'b0010});
    exp_q.push_back({4'd4, 4'b0100});
    send(1, 1);
    send(2, 1);
    send(4, 1);
    drain();
    chk("busy_0111", b.busy_o, 4'b0111);
    done(4'b0010, 0);
    chk("busy_0101", b.busy_o, 4'b0101);
    exp_q.push_back({4'd5, 4'b1010});
    send(5, 2);
    drain();
    chk("busy_1111", b.busy_o, 4'b1111);
    send(6, 1);
    repeat (4) tick();
    chk("blocked_lvalid", b.launch_valid_o, 0);
    chk("blocked_qcount", b.q_count_o, 1);
    exp_q.push_back({4'd6, 4'b0001});
    done(4'b0001, 0);
    drain();
    chk("busy_after_unblock", b.busy_o, 4'b1111);
    chk("qcount_after_unblock", b.q_count_o, 0);
    done(4'b1111, 0);
    // Fill FIFO while dispatch disabled, then release in order
    b.enable_i = 0;
    for (int i = 0; i < 4; i++) send(4'(8 + i), 1);
    chk("full_qcount", b.q_count_o, 4);
    chk("full_ready", b.req_ready_o, 0);
    chk("disabled_lvalid", b.launch_valid_o, 0);
    exp_q.push_back({4'd8, 4'b0001});
    exp_q.push_back({4'd9, 4'b0010});
    exp_q.push_back({4'd10, 4'b0100});
    exp_q.push_back({4'd11, 4'b1000});
    b.enable_i = 1;
    drain();
    chk("fill_busy", b.busy_o, 4'b1111);
    chk("fill_qcount", b.q_count_o, 0);
    done(4'b1111, 0);
    // Illegal requests and releases of idle columns
    send(7, 0);
    chk("err_nc0", b.err_o, 1);
    chk("err_nc0_qcount", b.q_count_o, 0);
    tick();
    chk("err_nc0_clear", b.err_o, 0);
    send(7, 5);
    chk("err_nc5", b.err_o, 1);
    chk("err_nc5_qcount", b.q_count_o, 0);
    done(4'b0100, 0);
    chk("err_idle_done", b.err_o, 1);
    chk("idle_done_busy", b.busy_o, 0);
    tick();
    chk("err_pulse_end", b.err_o, 0);
    // Sticky interrupt: set beats clear
    chk("intr_set", b.intr_o, 1);
    b.intr_clr_i = 1;
    tick();
    b.intr_clr_i = 0;
    chk("intr_cleared", b.intr_o, 0);
    done(4'b0000, 1);
    chk("intr_set_wins", b.intr_o, 1);
    b.intr_clr_i = 1;
    tick();
    b.intr_clr_i = 0;
    chk("intr_clr_alone", b.intr_o, 0);
    // Reset while a launch is pending
    b.launch_ready_i = 0;
    send(2, 3);
    tick();
    chk("pending_lvalid", b.launch_valid_o, 1);
    chk("pending_busy", b.busy_o, 4'b0111);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_lvalid", b.launch_valid_o, 0);
    chk("rst_mid_busy", b.busy_o, 0);
    chk("rst_mid_qcount", b.q_count_o, 0);
    b.launch_ready_i = 1;
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cgra_kernel_scheduler.md
CGRA_KERNEL_SCHEDULER -- requirements
Module: cgra_kernel_scheduler

Interface
REQ-001 SHALL have parameter N_COLS, default 4: number of CGRA columns scheduled.
REQ-002 SHALL have parameter KID_W, default 4: kernel-ID width.
REQ-003 SHALL have parameter QDEPTH, default 4 (power of 2): request FIFO depth.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have port enable_i  in  1  dispatch enable; 0 blocks new allocations (e.g. domain powered down).
REQ-008 SHALL have ports req_valid_i in 1 / req_ready_o out 1: kernel request handshake.
REQ-009 SHALL have ports req_kid_i in KID_W / req_ncols_i in $clog2(N_COLS)+1: kernel ID, columns needed.
REQ-010 SHALL have ports launch_valid_o out 1 / launch_ready_i in 1: launch handshake to CGRA.
REQ-011 SHALL have ports launch_kid_o out KID_W / launch_col_mask_o out N_COLS: launched kernel and its columns.
REQ-012 SHALL have ports done_valid_i in 1 / done_col_mask_i in N_COLS: columns released by a finished kernel.
REQ-013 SHALL have ports intr_o out 1 (sticky completion interrupt) / intr_clr_i in 1.
REQ-014 SHALL have ports busy_o out N_COLS, q_count_o out $clog2(QDEPTH)+1, err_o out 1 (one-cycle pulse).

Function
REQ-015 SHALL accept a request when req_valid_i & req_ready_o; req_ready_o = ~fifo_full & ~rst_i.
REQ-016 SHALL drop (not enqueue) a request with req_ncols_i = 0 or > N_COLS and pulse err_o next cycle.
REQ-017 SHALL service the FIFO strictly in order; head-of-line request blocks later ones.
REQ-018 SHALL implement FSM IDLE, LAUNCH; reset state IDLE.
REQ-019 IDLE: if FIFO non-empty, enable_i=1 and popcount(~busy) >= head.ncols -> pop head, allocate mask of the head.ncols lowest-index free columns, register kid/mask, set those busy bits, go LAUNCH.
REQ-020 IDLE: otherwise stay IDLE, no pop.
REQ-021 LAUNCH: launch_valid_o=1 with stable kid/mask; on launch_ready_i=1 go IDLE same edge.
REQ-022 SHALL keep launch_valid_o asserted regardless of enable_i once in LAUNCH.
REQ-023 Accept at edge t -> earliest launch_valid_o=1 in cycle t+2; back-to-back launches spaced >= 2 cycles.
REQ-024 Free-column computation SHALL use registered busy only (no same-cycle bypass of done_col_mask_i).
REQ-025 busy_next = (busy & ~(done_valid_i ? done_col_mask_i : 0)) | alloc_mask.
REQ-026 done_col_mask_i bits set for non-busy columns SHALL be ignored and pulse err_o next cycle.
REQ-027 done_valid_i=1 SHALL set intr_o next cycle; intr_clr_i clears it; simultaneous set and clear -> set wins.
REQ-028 Simultaneous enqueue and pop SHALL leave q_count_o unchanged; FIFO pointers wrap modulo QDEPTH.
REQ-029 q_count_o SHALL equal FIFO occupancy; busy_o SHALL equal registered busy mask.

Reset
REQ-030 While rst_i=1 at a rising edge: FSM=IDLE, FIFO empty, busy=0, intr_o=0, err_o=0, launch regs=0.
REQ-031 Reset mid-LAUNCH SHALL abandon the pending launch; launch_valid_o=0 the cycle after reset edge.
REQ-032 Outputs after reset: req_ready_o=1 (once rst_i=0), launch_valid_o=0, busy_o=0, q_count_o=0, intr_o=0.

Verification
REQ-033 Enqueue kid=3 ncols=2, launch_ready_i=1 -> launch_valid_o at t+2, kid=3, mask=4'b0011, busy_o=4'b0011.
REQ-034 busy=4'b0101, enqueue ncols=2 -> mask=4'b1010; then enqueue ncols=1 -> blocked until done mask 4'b0001 frees col 0.
REQ-035 Fill FIFO with 4 requests, enable_i=0 -> req_ready_o=0, q_count_o=4; enable_i=1 -> in-order launches.
REQ-036 req_ncols_i=0 and 5 -> err_o pulses, q_count_o stays 0; done mask on idle column -> err_o pulse, busy unchanged.
REQ-037 done_valid_i and intr_clr_i same cycle -> intr_o=1; intr_clr_i alone next -> intr_o=0.
REQ-038 rst_i during LAUNCH with launch_ready_i=0 -> launch_valid_o=0, busy_o=0, q_count_o=0 next cycle.
